// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, streams word reads to a 1-cycle imem, queues returns for decode.
// Latency: issue in cycle N, data enqueued at end of N+1, out_valid in N+2; one instruction/cycle steady state.
// Backpressure: out_ready=0 stops issue once queue occupancy + in-flight read reaches FQ_DEPTH; PC holds.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   imem_req/imem_addr  read enable and word-aligned byte address to instruction memory
//   imem_rdata          read data, valid the cycle after imem_req
//   redirect_valid/_pc  branch/jump redirect from execute; flushes queue and in-flight read
//   out_valid/out_ready valid/ready handshake to decode
//   out_instr/out_pc    head instruction and its PC (zero when the queue is empty)
//   out_misalign        only with FETCH_MISALIGN_CHECK_EN: head entry is a misaligned-redirect marker
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When defined, a redirect to a non-word-aligned
// target enqueues a single marker entry instead of fetching, then stalls issue until the next redirect.
// When undefined, the two low bits of redirect_pc are cleared before loading the PC.

module fetch_unit #(
    parameter int unsigned       XLEN     = 32,
    parameter int unsigned       ILEN     = 32,
    parameter int unsigned       FQ_DEPTH = 4,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            out_misalign
`endif
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Queue storage; contents are qualified by count_q so they need no reset.
    logic [ILEN-1:0]  fq_instr_q [FQ_DEPTH];
    logic [XLEN-1:0]  fq_pc_q    [FQ_DEPTH];

`ifdef FETCH_MISALIGN_CHECK_EN
    logic             stall_q, stall_d;       // issue blocked after a misaligned redirect
    logic             mis_pend_q, mis_pend_d; // marker entry waiting to be enqueued
    logic             fq_mis_q   [FQ_DEPTH];
`endif

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic             issue_blk;
    logic             issue;
    logic             enq_vld;
    logic             deq_vld;
    logic             enq_mis;
    logic [ILEN-1:0]  enq_instr;
    logic [XLEN-1:0]  enq_pc;
    logic [CNT_W:0]   credit_used;

    always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
        issue_blk = stall_q;
`else
        issue_blk = 1'b0;
`endif
        // Occupancy plus the read still in flight must leave room for the new read's return.
        credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

        // rst gates the request so it drops the instant reset asserts, not at the next edge.
        issue = rst && !redirect_valid && !issue_blk && (credit_used < {1'b0, DEPTH_C});

        // Redirect wins over everything: a return landing in the redirect cycle is dropped.
`ifdef FETCH_MISALIGN_CHECK_EN
        enq_vld = (inflight_q || mis_pend_q) && !redirect_valid;
        enq_mis = mis_pend_q;
`else
        enq_vld = inflight_q && !redirect_valid;
        enq_mis = 1'b0;
`endif
        deq_vld = out_valid && out_ready && !redirect_valid;

        // The marker entry carries the (misaligned) PC and a zero instruction word.
        if (enq_mis) begin
            enq_instr = '0;
            enq_pc    = pc_q;
        end else begin
            enq_instr = imem_rdata;
            enq_pc    = inflight_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        stall_d       = stall_q;
        mis_pend_d    = mis_pend_q;
`endif

        if (redirect_valid) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            pc_d       = redirect_pc;
            stall_d    = (redirect_pc[1:0] != 2'b00);
            mis_pend_d = (redirect_pc[1:0] != 2'b00);
`else
            pc_d       = redirect_pc & ~XLEN'(3);
`endif
        end else begin
            if (issue) begin
                pc_d          = pc_q + XLEN'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end else begin
                inflight_d    = 1'b0;
            end

`ifdef FETCH_MISALIGN_CHECK_EN
            if (mis_pend_q) begin
                mis_pend_d = 1'b0;
            end
`endif
            if (enq_vld) begin
                tail_d = tail_q + 1'b1;
            end
            if (deq_vld) begin
                head_d = head_q + 1'b1;
            end

            case ({enq_vld, deq_vld})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            stall_q       <= 1'b0;
            mis_pend_q    <= 1'b0;
`endif
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            stall_q       <= stall_d;
            mis_pend_q    <= mis_pend_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (enq_vld) begin
            fq_instr_q[tail_q] <= enq_instr;
            fq_pc_q[tail_q]    <= enq_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
            fq_mis_q[tail_q]   <= enq_mis;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req  = issue;
        imem_addr = pc_q;
        out_valid = (count_q != '0);
        // Head fields are forced to zero when empty so stale storage never leaks out.
        out_instr = out_valid ? fq_instr_q[head_q] : '0;
        out_pc    = out_valid ? fq_pc_q[head_q]    : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
        out_misalign = out_valid ? fq_mis_q[head_q] : 1'b0;
`endif
    end

`ifndef SYNTHESIS
    // The credit check on issue should make a write into a full queue impossible.
    fq_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(enq_vld && !deq_vld && (count_q == DEPTH_C)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        out_misalign;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN(32), .ILEN(32), .FQ_DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .out_misalign(out_misalign)
`endif
    );

    // Reference model: the queue seen by decode, the PC, and the single outstanding read.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          mis;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_infl_pc;
    bit          m_infl;
    bit          m_stall;
    bit          m_mis_pend;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cnt;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] instr_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc       = RPC;
        m_infl     = 1'b0;
        m_infl_pc  = '0;
        m_stall    = 1'b0;
        m_mis_pend = 1'b0;
    endtask

    // One clock cycle: entered just after a negedge with inputs already driven.
    task automatic step();
        bit          exp_req;
        bit          fire;
        bit          hs;
        logic [31:0] fire_addr;
        if (!rst) model_reset();
        #1;
        exp_req = rst && !redirect_valid && !m_stall && ((m_q.size() + int'(m_infl)) < DEPTH);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("out_pc", out_pc, m_q[0].pc);
            check("out_instr", out_instr, m_q[0].instr);
`ifdef FETCH_MISALIGN_CHECK_EN
            check("out_misalign", 32'(out_misalign), 32'(m_q[0].mis));
`endif
        end else begin
            check("out_pc_empty", out_pc, 32'h0);
            check("out_instr_empty", out_instr, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
            check("out_misalign_empty", 32'(out_misalign), 32'h0);
`endif
        end
        fire      = exp_req;
        fire_addr = m_pc;
        hs        = (m_q.size() != 0) && out_ready;

        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (redirect_valid) begin
            m_q.delete();
            m_infl = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            m_pc       = redirect_pc;
            m_stall    = (redirect_pc[1:0] != 2'b00);
            m_mis_pend = (redirect_pc[1:0] != 2'b00);
`else
            m_pc = {redirect_pc[31:2], 2'b00};
`endif
        end else begin
            if (hs) void'(m_q.pop_front());
            if (m_infl) m_q.push_back('{pc: m_infl_pc, instr: instr_of(m_infl_pc), mis: 1'b0});
            if (m_mis_pend) begin
                m_q.push_back('{pc: m_pc, instr: 32'h0, mis: 1'b1});
                m_mis_pend = 1'b0;
            end
            if (fire) begin
                m_infl    = 1'b1;
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end

        @(negedge clk);
        // Synchronous memory: data for this cycle's read appears next cycle; garbage otherwise.
        imem_rdata = fire ? instr_of(fire_addr) : $urandom;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        run(2);
        rst = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        @(negedge clk);

        // Reset values, then sequential fetch and 2-cycle issue-to-output latency.
        #1;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        run(2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("seq_req", 32'(imem_req), 32'h1);
            check("seq_addr", imem_addr, RPC + 32'(4 * i));
            if (i == 1) check("lat_valid_n1", 32'(out_valid), 32'h0);
            if (i == 2) begin
                check("lat_valid_n2", 32'(out_valid), 32'h1);
                check("lat_pc_n2", out_pc, RPC);
            end
            step();
        end
        run(10);

        // Backpressure from reset: exactly DEPTH reads, PC held, then ordered drain.
        out_ready = 1'b0;
        do_reset();
        req_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req) req_cnt++;
            step();
        end
        check("bp_pulses", 32'(req_cnt), 32'(DEPTH));
        #1;
        check("bp_pc_hold", imem_addr, 32'h110);
        out_ready = 1'b1;
        #1;
        check("bp_head", out_pc, 32'h100);
        check("bp_no_issue", 32'(imem_req), 32'h0);
        step();
        #1;
        check("bp_resume_req", 32'(imem_req), 32'h1);
        check("bp_resume_addr", imem_addr, 32'h110);
        run(12);

        // Redirect with 3 queued entries and a read in flight.
        out_ready = 1'b0;
        do_reset();
        run(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        check("rd_flush_valid", 32'(out_valid), 32'h0);
        check("rd_req", 32'(imem_req), 32'h1);
        check("rd_addr", imem_addr, 32'h400);
        run(2);
        #1;
        check("rd_first_pc", out_pc, 32'h400);
        run(6);

        // Redirect coinciding with a dequeue from a full queue.
        out_ready = 1'b0;
        do_reset();
        run(6);
        #1;
        check("full_valid", 32'(out_valid), 32'h1);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        step();
        redirect_valid = 1'b0;
        #1;
        check("rdq_empty", 32'(out_valid), 32'h0);
        check("rdq_addr", imem_addr, 32'h400);
        run(8);

        // Asynchronous reset mid-stream.
        run(3);
        #2;
        rst = 1'b0;
        #1;
        check("arst_req", 32'(imem_req), 32'h0);
        check("arst_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        step();
        rst = 1'b1;
        #1;
        check("arst_restart", imem_addr, RPC);
        run(6);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect: one marker entry, no reads until the next redirect.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h402;
        step();
        redirect_valid = 1'b0;
        step();
        #1;
        check("mis_valid", 32'(out_valid), 32'h1);
        check("mis_pc", out_pc, 32'h402);
        check("mis_flag", 32'(out_misalign), 32'h1);
        run(4);
        out_ready = 1'b1;
        run(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        step();
        redirect_valid = 1'b0;
        #1;
        check("mis_restart_req", 32'(imem_req), 32'h1);
        check("mis_restart_addr", imem_addr, 32'h500);
        run(6);
`endif

        // Randomised traffic: decode stalls, redirects (incl. back-to-back), rare resets.
        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            rst            = ($urandom_range(0, 199) != 0);
            step();
        end
        rst            = 1'b1;
        redirect_valid = 1'b0;
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
